// File: rtl/picosoc_mem_arbiter_if.sv
// PicoSoC native memory bus: a single valid/ready request channel with write data,
// byte strobes and read data. The master side issues requests, the slave side answers.
interface picosoc_mem_arbiter_if;
  logic        valid;
  logic        ready;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic [31:0] rdata;

  modport master (output valid, addr, wdata, wstrb, input ready, rdata);
  modport slave  (input valid, addr, wdata, wstrb, output ready, rdata);
endinterface

// File: rtl/picosoc_mem_arbiter.sv
// Two-master arbiter for the PicoSoC native memory bus: one transaction at a time,
// grant held until the slave completes, hung transactions terminated with an error word.
module picosoc_mem_arbiter #(
  parameter int          PRIORITY_MODE  = 0,
  parameter int          TIMEOUT_CYCLES = 255,
  parameter logic [31:0] ERR_WORD       = 32'hDEAD_BEEF
) (
  input  logic                  clk,
  input  logic                  reset,
  picosoc_mem_arbiter_if.slave  m0,
  picosoc_mem_arbiter_if.slave  m1,
  picosoc_mem_arbiter_if.master s,
  output logic [1:0]            grant,
  output logic                  timeout_irq
);

  localparam bit            TO_EN  = (TIMEOUT_CYCLES > 0);
  localparam int            CW     = TO_EN ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CW-1:0] T_LAST = TO_EN ? CW'(TIMEOUT_CYCLES - 1) : '0;
  localparam logic [CW-1:0] T_MAX  = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  state_t        state;
  state_t        state_next;
  logic          last_grant;
  logic          last_grant_next;
  logic [CW-1:0] tcount;

  logic          own_valid;
  logic [31:0]   own_addr;
  logic [31:0]   own_wdata;
  logic [3:0]    own_wstrb;
  logic          complete;
  logic          timeout_hit;
  logic          abort;
  logic          finish;
  logic [31:0]   resp_data;

  always_comb begin
    own_valid = 1'b0;
    own_addr  = '0;
    own_wdata = '0;
    own_wstrb = '0;
    case (state)
      OWN0: begin
        own_valid = m0.valid;
        own_addr  = m0.addr;
        own_wdata = m0.wdata;
        own_wstrb = m0.wstrb;
      end
      OWN1: begin
        own_valid = m1.valid;
        own_addr  = m1.addr;
        own_wdata = m1.wdata;
        own_wstrb = m1.wstrb;
      end
      default: ;
    endcase
  end

  // A slave ready in the final allowed cycle still counts as a normal completion.
  assign complete    = own_valid && s.ready;
  assign timeout_hit = TO_EN && own_valid && !s.ready && (tcount == T_LAST);
  assign abort       = (state != IDLE) && !own_valid;
  assign finish      = complete || timeout_hit;
  assign resp_data   = timeout_hit ? ERR_WORD : s.rdata;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      tcount     <= '0;
    end else begin
      state      <= state_next;
      last_grant <= last_grant_next;
      if (state == IDLE)
        tcount <= '0;
      else if (!s.ready && tcount != T_MAX)
        tcount <= tcount + CW'(1);
    end
  end

  always_comb begin
    state_next      = state;
    last_grant_next = last_grant;
    case (state)
      IDLE: begin
        if (m0.valid && m1.valid)
          state_next = ((PRIORITY_MODE != 0) || last_grant) ? OWN0 : OWN1;
        else if (m0.valid)
          state_next = OWN0;
        else if (m1.valid)
          state_next = OWN1;
      end
      OWN0: begin
        if (finish) begin
          state_next      = IDLE;
          last_grant_next = 1'b0;
        end else if (abort) begin
          state_next = IDLE;
        end
      end
      OWN1: begin
        if (finish) begin
          state_next      = IDLE;
          last_grant_next = 1'b1;
        end else if (abort) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // The non-owner never sees ready; its request simply waits in IDLE arbitration.
  always_comb begin
    grant       = 2'b00;
    s.valid     = own_valid && !timeout_hit;
    s.addr      = own_addr;
    s.wdata     = own_wdata;
    s.wstrb     = own_wstrb;
    m0.ready    = 1'b0;
    m0.rdata    = '0;
    m1.ready    = 1'b0;
    m1.rdata    = '0;
    timeout_irq = timeout_hit;
    case (state)
      OWN0: begin
        grant    = 2'b01;
        m0.ready = finish;
        m0.rdata = finish ? resp_data : '0;
      end
      OWN1: begin
        grant    = 2'b10;
        m1.ready = finish;
        m1.rdata = finish ? resp_data : '0;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_picosoc_mem_arbiter.sv
// Scoreboard bench: a round-robin/short-timeout arbiter and a fixed-priority arbiter,
// each with a latency-programmable slave model; completions are matched per master.
module tb_picosoc_mem_arbiter;

  localparam logic [31:0] SLV_KEY = 32'h1234_5668;
  localparam logic [31:0] ERR     = 32'hDEAD_BEEF;

  typedef struct {
    logic [31:0] data;
    bit          irq;
  } exp_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   checks   = 0;
  int   errors   = 0;
  int   cyc      = 0;
  int   irq_seen = 0;
  int   irq_exp  = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  logic [3:0]  mv = '0;
  logic [31:0] ma [4] = '{default: '0};
  logic [31:0] mw [4] = '{default: '0};
  logic [3:0]  ms [4] = '{default: '0};
  logic [3:0]  mr;
  logic [31:0] mrd [4];
  logic [1:0]  sv;
  logic [1:0]  sr;
  logic [31:0] sa [2];
  logic [31:0] sw [2];
  logic [3:0]  sst [2];
  logic [1:0]  gnt [2];
  logic [1:0]  tirq;
  int          slat [2] = '{1, 1};
  bit   [1:0]  shang = '0;
  logic [7:0]  scnt [2] = '{8'd0, 8'd0};

  exp_t expq [4][$];
  int   glog [2][$];
  int   rcyc [2][$];

  picosoc_mem_arbiter_if m_if [4] ();
  picosoc_mem_arbiter_if s_if [2] ();

  generate
    for (genvar g = 0; g < 4; g++) begin : g_m
      assign m_if[g].valid = mv[g];
      assign m_if[g].addr  = ma[g];
      assign m_if[g].wdata = mw[g];
      assign m_if[g].wstrb = ms[g];
      assign mr[g]         = m_if[g].ready;
      assign mrd[g]        = m_if[g].rdata;
    end
    for (genvar d = 0; d < 2; d++) begin : g_s
      assign sv[d]          = s_if[d].valid;
      assign sa[d]          = s_if[d].addr;
      assign sw[d]          = s_if[d].wdata;
      assign sst[d]         = s_if[d].wstrb;
      assign s_if[d].ready  = (gnt[d] != 2'b00) && !shang[d] && (scnt[d] == 8'(slat[d]));
      assign sr[d]          = s_if[d].ready;
      assign s_if[d].rdata  = s_if[d].addr ^ SLV_KEY;
    end
  endgenerate

  picosoc_mem_arbiter #(.PRIORITY_MODE(0), .TIMEOUT_CYCLES(4), .ERR_WORD(ERR)) dut_rr (
    .clk(clk), .reset(reset), .m0(m_if[0]), .m1(m_if[1]), .s(s_if[0]),
    .grant(gnt[0]), .timeout_irq(tirq[0])
  );

  picosoc_mem_arbiter #(.PRIORITY_MODE(1), .TIMEOUT_CYCLES(255), .ERR_WORD(ERR)) dut_fp (
    .clk(clk), .reset(reset), .m0(m_if[2]), .m1(m_if[3]), .s(s_if[1]),
    .grant(gnt[1]), .timeout_irq(tirq[1])
  );

  // Slave model: counts granted cycles and answers after slat cycles unless hung.
  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (gnt[d] === 2'b00 || sr[d] === 1'b1)
        scnt[d] <= 8'd0;
      else
        scnt[d] <= scnt[d] + 8'd1;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=%h expected=%h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic onReady(input int p);
    int   d    = p / 2;
    int   port = p % 2;
    exp_t e;
    checkOutput("ready_pending", 32'(expq[p].size()), 32'd1);
    if (expq[p].size() > 0) begin
      e = expq[p].pop_front();
      checkOutput("rdata", mrd[p], e.data);
      checkOutput("irq_at_done", 32'(tirq[d]), 32'(e.irq));
      checkOutput("s_valid_at_done", 32'(sv[d]), 32'(!e.irq));
    end
    checkOutput("grant_at_done", 32'(gnt[d]), 32'(1 << port));
    checkOutput("other_ready", 32'(mr[d*2 + 1 - port]), 32'd0);
    glog[d].push_back(port);
    rcyc[d].push_back(cyc);
  endtask

  always @(negedge clk) begin
    if (tirq[0] === 1'b1) irq_seen++;
    if (tirq[1] === 1'b1) irq_seen++;
    for (int p = 0; p < 4; p++)
      if (mr[p] === 1'b1) onReady(p);
  end

  // Called just after a rising edge; leaves valid high when hold is set so the
  // next call presents a back-to-back request.
  task automatic applyStimulus(input int idx, input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [3:0] strb, input logic [31:0] exp_data,
                               input bit exp_irq, input int exp_lat, input bit hold);
    exp_t e;
    int   start;
    int   n;
    bit   seen;
    e.data = exp_data;
    e.irq  = exp_irq;
    expq[idx].push_back(e);
    if (exp_irq) irq_exp++;
    ma[idx] = addr;
    mw[idx] = wdata;
    ms[idx] = strb;
    mv[idx] = 1'b1;
    start = cyc;
    n     = 0;
    seen  = 1'b0;
    while (!seen && n < 100) begin
      @(negedge clk);
      if (mr[idx] === 1'b1) seen = 1'b1;
      else n++;
    end
    checkOutput("ready_seen", 32'(seen), 32'd1);
    if (!seen) void'(expq[idx].pop_back());
    if (seen && exp_lat >= 0) checkOutput("latency", 32'(cyc - start), 32'(exp_lat));
    @(posedge clk);
    #1;
    if (!hold) mv[idx] = 1'b0;
  endtask

  task automatic doReset();
    mv    = '0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int total;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_grant_a", 32'(gnt[0]), 32'd0);
    checkOutput("rst_grant_b", 32'(gnt[1]), 32'd0);
    checkOutput("rst_s_valid", 32'(sv), 32'd0);
    checkOutput("rst_ready", 32'(mr), 32'd0);
    checkOutput("rst_irq", 32'(tirq), 32'd0);
    checkOutput("rst_s_addr", sa[0], 32'd0);
    reset = 1'b0;

    $display("[TB] single master read, slave latency 2");
    slat[0] = 2;
    fork
      applyStimulus(0, 32'h0000_0010, 32'd0, 4'b0000, 32'h1234_5678, 1'b0, 3, 1'b0);
      begin
        @(negedge clk);
        checkOutput("t1_idle_s_valid", 32'(sv[0]), 32'd0);
        checkOutput("t1_idle_grant", 32'(gnt[0]), 32'd0);
        @(negedge clk);
        checkOutput("t1_s_valid", 32'(sv[0]), 32'd1);
        checkOutput("t1_s_addr", sa[0], 32'h0000_0010);
        checkOutput("t1_grant", 32'(gnt[0]), 32'd1);
      end
    join

    $display("[TB] round-robin contention");
    doReset();
    glog[0].delete();
    rcyc[0].delete();
    slat[0] = 1;
    fork
      for (int k = 0; k < 4; k++)
        applyStimulus(0, 32'h100 + 32'(k*4), 32'd0, 4'b0000,
                      (32'h100 + 32'(k*4)) ^ SLV_KEY, 1'b0, -1, k < 3);
      for (int k = 0; k < 4; k++)
        applyStimulus(1, 32'h200 + 32'(k*4), 32'hA000 + 32'(k), 4'b1111,
                      (32'h200 + 32'(k*4)) ^ SLV_KEY, 1'b0, -1, k < 3);
    join
    checkOutput("rr_count", 32'(glog[0].size()), 32'd8);
    for (int i = 0; i < glog[0].size() && i < 8; i++)
      checkOutput("rr_order", 32'(glog[0][i]), 32'(i % 2));
    for (int i = 1; i < rcyc[0].size(); i++)
      checkOutput("rr_period", 32'(rcyc[0][i] - rcyc[0][i-1]), 32'd3);

    $display("[TB] fixed priority contention");
    slat[1] = 1;
    fork
      for (int k = 0; k < 6; k++)
        applyStimulus(2, 32'h400 + 32'(k*4), 32'd0, 4'b0000,
                      (32'h400 + 32'(k*4)) ^ SLV_KEY, 1'b0, -1, k < 5);
      applyStimulus(3, 32'h0000_0800, 32'd0, 4'b0000, 32'h0000_0800 ^ SLV_KEY, 1'b0, -1, 1'b0);
    join
    checkOutput("fp_count", 32'(glog[1].size()), 32'd7);
    for (int i = 0; i < glog[1].size() && i < 7; i++)
      checkOutput("fp_order", 32'(glog[1][i]), (i < 6) ? 32'd0 : 32'd1);

    $display("[TB] timeout on a hung write");
    shang[0] = 1'b1;
    fork
      applyStimulus(1, 32'h0200_0008, 32'h0000_00A5, 4'b0001, ERR, 1'b1, 4, 1'b0);
      begin
        @(negedge clk);
        @(negedge clk);
        checkOutput("t4_s_addr", sa[0], 32'h0200_0008);
        checkOutput("t4_s_wdata", sw[0], 32'h0000_00A5);
        checkOutput("t4_s_wstrb", 32'(sst[0]), 32'd1);
        checkOutput("t4_s_valid", 32'(sv[0]), 32'd1);
        checkOutput("t4_grant", 32'(gnt[0]), 32'd2);
      end
    join
    checkOutput("t4_idle_grant", 32'(gnt[0]), 32'd0);
    checkOutput("t4_idle_irq", 32'(tirq[0]), 32'd0);

    $display("[TB] slave ready in the timeout cycle");
    shang[0] = 1'b0;
    slat[0]  = 3;
    applyStimulus(0, 32'h0000_0040, 32'd0, 4'b0000, 32'h0000_0040 ^ SLV_KEY, 1'b0, 4, 1'b0);

    $display("[TB] reset during a master 1 transaction");
    shang[0] = 1'b1;
    ma[1] = 32'h0300_0000;
    ms[1] = 4'b0000;
    mv[1] = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checkOutput("t6_s_valid_before", 32'(sv[0]), 32'd1);
    checkOutput("t6_grant_before", 32'(gnt[0]), 32'd2);
    reset = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("t6_grant_after", 32'(gnt[0]), 32'd0);
    checkOutput("t6_s_valid_after", 32'(sv[0]), 32'd0);
    checkOutput("t6_ready_after", 32'(mr[1:0]), 32'd0);
    checkOutput("t6_irq_after", 32'(tirq[0]), 32'd0);
    reset    = 1'b0;
    shang[0] = 1'b0;
    slat[0]  = 1;
    glog[0].delete();
    fork
      applyStimulus(0, 32'h0000_0500, 32'd0, 4'b0000, 32'h0000_0500 ^ SLV_KEY, 1'b0, -1, 1'b0);
      applyStimulus(1, 32'h0000_0600, 32'd0, 4'b0000, 32'h0000_0600 ^ SLV_KEY, 1'b0, -1, 1'b0);
    join
    checkOutput("t6_count", 32'(glog[0].size()), 32'd2);
    if (glog[0].size() > 0) checkOutput("t6_first_owner", 32'(glog[0][0]), 32'd0);

    repeat (3) @(posedge clk);
    #1;
    checkOutput("irq_total", 32'(irq_seen), 32'(irq_exp));
    total = 0;
    for (int p = 0; p < 4; p++) total += expq[p].size();
    checkOutput("scoreboard_left", 32'(total), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
